// File: rtl/axi4_pkg.sv
// Shared AXI4 response codes, FSM state encodings and decode helpers for the SRAM responder.
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_e;

    // Per-transaction tag captured at the address handshake.
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } txn_tag_t;

    // Decode error wins over a malformed (burst or oversize) request.
    function automatic logic [1:0] calc_resp(input logic hit, input logic [7:0] len,
                                             input logic [2:0] size);
        if (!hit) return RESP_DECERR;
        if ((len != 8'd0) || (size > SIZE_WORD)) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_sram_responder_if.sv
// Single-beat AXI4 bus between the LSU master and the SRAM responder.
interface axi4_sram_responder_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rresp, rdata, rlast, rid
    );

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rresp, rdata, rlast, rid
    );

endinterface

// File: rtl/axi4_lat_cnt.sv
// Loadable down-counter that times the response latency of one channel.
module axi4_lat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/axi4_sram_responder.sv
// AXI4 single-beat responder backed by a word-addressed 32-bit SRAM with fixed read/write latency.
module axi4_sram_responder
    import axi4_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned WR_LAT      = 2
) (
    input logic                  clock,
    input logic                  reset,
    axi4_sram_responder_if.slave bus
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam int unsigned CNT_W      = 8;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

    function automatic logic addr_hit(input logic [31:0] addr);
        return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < SPAN_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- read channel ----------------
    r_state_e         r_state, r_state_nxt;
    logic             ar_hs_c, r_load_c, r_dec_c, r_zero_c, r_sample_c;
    logic [IDX_W-1:0] ar_idx;
    txn_tag_t         ar_tag;

    // Read FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_state_nxt;
    end

    // Read FSM next state and counter control.
    always_comb begin
        r_state_nxt = r_state;
        ar_hs_c     = 1'b0;
        r_load_c    = 1'b0;
        r_dec_c     = 1'b0;
        r_sample_c  = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_hs_c = bus.arvalid & bus.arready;
                if (ar_hs_c) begin
                    r_load_c    = 1'b1;
                    r_state_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_zero_c) begin
                    r_sample_c  = 1'b1;
                    r_state_nxt = R_RESP;
                end else begin
                    r_dec_c = 1'b1;
                end
            end
            R_RESP: begin
                if (bus.rvalid & bus.rready) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    axi4_lat_cnt #(.W(CNT_W)) u_rd_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (r_load_c),
        .load_val (RD_LOAD),
        .dec      (r_dec_c),
        .zero_c   (r_zero_c)
    );

    // Read request capture and registered R-channel outputs; data is sampled on entry to R_RESP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.arready <= 1'b1;
            bus.rvalid  <= 1'b0;
            bus.rlast   <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= RESP_OKAY;
            bus.rid     <= '0;
            ar_idx      <= '0;
            ar_tag      <= '0;
        end else begin
            bus.arready <= (r_state_nxt == R_IDLE);
            bus.rvalid  <= (r_state_nxt == R_RESP);
            bus.rlast   <= (r_state_nxt == R_RESP);
            if (ar_hs_c) begin
                ar_idx      <= addr_idx(bus.araddr);
                ar_tag.id   <= bus.arid;
                ar_tag.resp <= calc_resp(addr_hit(bus.araddr), bus.arlen, bus.arsize);
            end
            if (r_sample_c) begin
                bus.rdata <= (ar_tag.resp == RESP_OKAY) ? mem[ar_idx] : '0;
                bus.rresp <= ar_tag.resp;
                bus.rid   <= ar_tag.id;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_e         w_state, w_state_nxt;
    logic             aw_hs_c, w_hs_c, aw_have_c, w_have_c;
    logic             w_load_c, w_dec_c, w_zero_c, w_commit_c;
    logic             aw_held, w_held;
    logic [IDX_W-1:0] aw_idx;
    txn_tag_t         aw_tag;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;

    // Write FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_state_nxt;
    end

    // Write FSM next state; AW and W are collected independently while idle.
    always_comb begin
        w_state_nxt = w_state;
        aw_hs_c     = 1'b0;
        w_hs_c      = 1'b0;
        aw_have_c   = 1'b0;
        w_have_c    = 1'b0;
        w_load_c    = 1'b0;
        w_dec_c     = 1'b0;
        w_commit_c  = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_hs_c   = bus.awvalid & bus.awready;
                w_hs_c    = bus.wvalid & bus.wready;
                aw_have_c = aw_held | aw_hs_c;
                w_have_c  = w_held | w_hs_c;
                if (aw_have_c && w_have_c) begin
                    w_load_c    = 1'b1;
                    w_state_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_zero_c) begin
                    w_commit_c  = 1'b1;
                    w_state_nxt = W_RESP;
                end else begin
                    w_dec_c = 1'b1;
                end
            end
            W_RESP: begin
                if (bus.bvalid & bus.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    axi4_lat_cnt #(.W(CNT_W)) u_wr_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (w_load_c),
        .load_val (WR_LOAD),
        .dec      (w_dec_c),
        .zero_c   (w_zero_c)
    );

    // Write request capture and registered AW/W/B-channel outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= RESP_OKAY;
            bus.bid     <= '0;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_idx      <= '0;
            aw_tag      <= '0;
            w_data      <= '0;
            w_strb      <= '0;
        end else begin
            aw_held     <= (w_state_nxt == W_IDLE) && aw_have_c;
            w_held      <= (w_state_nxt == W_IDLE) && w_have_c;
            bus.awready <= (w_state_nxt == W_IDLE) && !aw_have_c;
            bus.wready  <= (w_state_nxt == W_IDLE) && !w_have_c;
            bus.bvalid  <= (w_state_nxt == W_RESP);
            if (aw_hs_c) begin
                aw_idx      <= addr_idx(bus.awaddr);
                aw_tag.id   <= bus.awid;
                aw_tag.resp <= calc_resp(addr_hit(bus.awaddr), bus.awlen, bus.awsize);
            end
            if (w_hs_c) begin
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
            end
            if (w_commit_c) begin
                bus.bresp <= aw_tag.resp;
                bus.bid   <= aw_tag.id;
            end
        end
    end

    // Array update on entry to W_RESP; error writes leave the array untouched.
    always_ff @(posedge clock) begin
        if (w_commit_c && (aw_tag.resp == RESP_OKAY)) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    // Single-beat only: burst type and wlast carry no information here.
    logic unused_c;
    assign unused_c = ^{bus.awburst, bus.arburst, bus.wlast};

endmodule

// File: tb/tb_axi4_sram_responder.sv
// Randomised self-checking bench for axi4_sram_responder against a word-array reference model.
module tb_axi4_sram_responder;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH  = 4096;
    localparam int          RD_LAT = 2;
    localparam int          WR_LAT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] model [int];

    axi4_sram_responder_if bus ();

    axi4_sram_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .RD_LAT      (RD_LAT),
        .WR_LAT      (WR_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Expected response from the decode / legality rules.
    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size);
        longint a = longint'(addr);
        if (a < longint'(BASE) || a >= longint'(BASE) + 4 * DEPTH) return 2'b11;
        if (len != 8'd0 || size > 3'd2) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr - BASE) >> 2);
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int          idx = idx_of(addr);
        logic [31:0] w   = model.exists(idx) ? model[idx] : 32'h0;
        for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
        model[idx] = w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives AW and W together, waits for B, returns what was observed; lat=-1 on handshake timeout.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                             output logic [1:0] resp, output logic [3:0] id_o, output int lat);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int n = 0;
        bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awsize = size; bus.awburst = 2'b01;
        bus.wdata = data; bus.wstrb = strb; bus.wlast = 1'b1;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_now = bus.awvalid && bus.awready;
            w_now  = bus.wvalid && bus.wready;
            tick();
            if (aw_now) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_now)  begin w_done = 1;  bus.wvalid = 1'b0;  end
            n++;
        end
        lat = -1; resp = 'x; id_o = 'x;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (aw_done && w_done) begin
            lat = 0;
            while (!bus.bvalid && lat < 50) begin tick(); lat++; end
            resp = bus.bresp; id_o = bus.bid;
            bus.bready = 1'b1; tick(); bus.bready = 1'b0;
        end
    endtask

    // Drives AR, waits for R, accepts it immediately; lat=-1 on handshake timeout.
    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, output logic [31:0] data, output logic [1:0] resp,
                            output logic [3:0] id_o, output logic last, output int lat);
        bit done = 0, now;
        int n = 0;
        bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arsize = size; bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        while (!done && n < 50) begin
            now = bus.arready;
            tick();
            if (now) begin done = 1; bus.arvalid = 1'b0; end
            n++;
        end
        bus.arvalid = 1'b0;
        lat = -1; data = 'x; resp = 'x; id_o = 'x; last = 'x;
        if (done) begin
            lat = 0;
            while (!bus.rvalid && lat < 50) begin tick(); lat++; end
            data = bus.rdata; resp = bus.rresp; id_o = bus.rid; last = bus.rlast;
            bus.rready = 1'b1; tick(); bus.rready = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.bready = 0; bus.rready = 0;
        bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++; if (bus.arready !== 1'b1) $display("FAIL reset_arready got=%b want=1", bus.arready); else n_pass++;
        n_checks++; if (bus.awready !== 1'b1) $display("FAIL reset_awready got=%b want=1", bus.awready); else n_pass++;
        n_checks++; if (bus.wready !== 1'b1) $display("FAIL reset_wready got=%b want=1", bus.wready); else n_pass++;
        n_checks++; if ({bus.rvalid, bus.bvalid, bus.rlast} !== 3'b000)
            $display("FAIL reset_valids got=%b want=000", {bus.rvalid, bus.bvalid, bus.rlast}); else n_pass++;
        n_checks++; if ({bus.rdata, bus.rresp, bus.bresp, bus.rid, bus.bid} !== 44'h0)
            $display("FAIL reset_payload got=%h want=0", {bus.rdata, bus.rresp, bus.bresp, bus.rid, bus.bid}); else n_pass++;
    endtask

    task automatic test_basic();
        logic [1:0] r; logic [3:0] id; logic [31:0] d; logic last; int lat;
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'h5, 8'd0, 3'd2, r, id, lat);
        model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        n_checks++; if (r !== 2'b00) $display("FAIL basic_bresp got=%b want=00", r); else n_pass++;
        n_checks++; if (id !== 4'h5) $display("FAIL basic_bid got=%h want=5", id); else n_pass++;
        n_checks++; if (lat != WR_LAT) $display("FAIL basic_wr_lat got=%0d want=%0d", lat, WR_LAT); else n_pass++;
        axi_read(32'h8000_0010, 4'hA, 8'd0, 3'd2, d, r, id, last, lat);
        n_checks++; if (d !== 32'hDEAD_BEEF) $display("FAIL basic_rdata got=%h want=deadbeef", d); else n_pass++;
        n_checks++; if (r !== 2'b00) $display("FAIL basic_rresp got=%b want=00", r); else n_pass++;
        n_checks++; if (id !== 4'hA) $display("FAIL basic_rid got=%h want=a", id); else n_pass++;
        n_checks++; if (last !== 1'b1) $display("FAIL basic_rlast got=%b want=1", last); else n_pass++;
        n_checks++; if (lat != RD_LAT) $display("FAIL basic_rd_lat got=%0d want=%0d", lat, RD_LAT); else n_pass++;
        n_checks++; if ({bus.rvalid, bus.rlast} !== 2'b00)
            $display("FAIL basic_r_drop got=%b want=00", {bus.rvalid, bus.rlast}); else n_pass++;
    endtask

    task automatic test_byte_strobe();
        logic [1:0] r; logic [3:0] id; logic [31:0] d; logic last; int lat;
        axi_write(32'h8000_0010, 32'h1122_3344, 4'hF, 4'h1, 8'd0, 3'd2, r, id, lat);
        model_write(32'h8000_0010, 32'h1122_3344, 4'hF);
        axi_write(32'h8000_0013, 32'hAB00_0000, 4'b1000, 4'h2, 8'd0, 3'd0, r, id, lat);
        model_write(32'h8000_0013, 32'hAB00_0000, 4'b1000);
        n_checks++; if (r !== 2'b00) $display("FAIL strobe_bresp got=%b want=00", r); else n_pass++;
        axi_read(32'h8000_0010, 4'h3, 8'd0, 3'd2, d, r, id, last, lat);
        n_checks++; if (d !== 32'hAB22_3344) $display("FAIL strobe_rdata got=%h want=ab223344", d); else n_pass++;
    endtask

    task automatic test_w_before_aw();
        int lat = 0;
        logic [31:0] d; logic [1:0] r; logic [3:0] id; logic last; int rl;
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        n_checks++; if (bus.wready !== 1'b0) $display("FAIL wfirst_wready got=%b want=0", bus.wready); else n_pass++;
        n_checks++; if (bus.awready !== 1'b1) $display("FAIL wfirst_awready got=%b want=1", bus.awready); else n_pass++;
        tick(); tick();
        n_checks++; if (bus.bvalid !== 1'b0) $display("FAIL wfirst_early_b got=%b want=0", bus.bvalid); else n_pass++;
        bus.awaddr = 32'h8000_0020; bus.awid = 4'h9; bus.awlen = 0; bus.awsize = 3'd2; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        while (!bus.bvalid && lat < 50) begin tick(); lat++; end
        n_checks++; if (lat != WR_LAT) $display("FAIL wfirst_lat got=%0d want=%0d", lat, WR_LAT); else n_pass++;
        n_checks++; if ({bus.bresp, bus.bid} !== {2'b00, 4'h9})
            $display("FAIL wfirst_b got=%h want=09", {bus.bresp, bus.bid}); else n_pass++;
        bus.bready = 1'b1; tick(); bus.bready = 1'b0;
        model_write(32'h8000_0020, 32'hCAFE_F00D, 4'hF);
        axi_read(32'h8000_0020, 4'h0, 8'd0, 3'd2, d, r, id, last, rl);
        n_checks++; if (d !== 32'hCAFE_F00D) $display("FAIL wfirst_rdata got=%h want=cafef00d", d); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] r; logic [3:0] id; logic last; int lat;
        axi_read(32'h7FFF_FFFC, 4'h1, 8'd0, 3'd2, d, r, id, last, lat);
        n_checks++; if ({r, d} !== {2'b11, 32'h0}) $display("FAIL err_decerr got=%b/%h want=11/0", r, d); else n_pass++;
        axi_read(32'h8000_4000, 4'h1, 8'd0, 3'd2, d, r, id, last, lat);
        n_checks++; if (r !== 2'b11) $display("FAIL err_above got=%b want=11", r); else n_pass++;
        axi_read(32'h8000_0010, 4'h2, 8'd1, 3'd2, d, r, id, last, lat);
        n_checks++; if ({r, d} !== {2'b10, 32'h0}) $display("FAIL err_arlen got=%b/%h want=10/0", r, d); else n_pass++;
        axi_write(32'h8000_0010, 32'h5555_5555, 4'hF, 4'h3, 8'd0, 3'd3, r, id, lat);
        n_checks++; if (r !== 2'b10) $display("FAIL err_awsize got=%b want=10", r); else n_pass++;
        axi_read(32'h8000_0010, 4'h4, 8'd0, 3'd2, d, r, id, last, lat);
        n_checks++; if (d !== model[4]) $display("FAIL err_unchanged got=%h want=%h", d, model[4]); else n_pass++;
        axi_write(32'h8000_3FFC, 32'h0BAD_CAFE, 4'hF, 4'h6, 8'd0, 3'd2, r, id, lat);
        model_write(32'h8000_3FFC, 32'h0BAD_CAFE, 4'hF);
        n_checks++; if (r !== 2'b00) $display("FAIL err_last_word got=%b want=00", r); else n_pass++;
    endtask

    task automatic test_random();
        int pool [8];
        logic [31:0] a, d, wd, ed; logic [1:0] r, er; logic [3:0] id, gid, s;
        logic [7:0] len; logic [2:0] size; logic last; int lat, k, mode;
        for (int i = 0; i < 8; i++) pool[i] = (i == 7) ? DEPTH - 1 : 100 + i * 301;
        for (int i = 0; i < 8; i++) begin
            wd = $urandom;
            axi_write(BASE + 32'(pool[i] * 4), wd, 4'hF, 4'h0, 8'd0, 3'd2, r, gid, lat);
            model_write(BASE + 32'(pool[i] * 4), wd, 4'hF);
        end
        repeat (40) begin
            k = $urandom_range(0, 7);
            a = BASE + 32'(pool[k] * 4) + 32'($urandom_range(0, 3));
            len = 8'd0; size = 3'($urandom_range(0, 2)); id = 4'($urandom);
            mode = $urandom_range(0, 6);
            if (mode == 0) len = 8'($urandom_range(1, 255));
            else if (mode == 1) size = 3'($urandom_range(3, 7));
            else if (mode == 2) a = BASE - 32'(4 * $urandom_range(1, 100));
            else if (mode == 3) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 1000));
            er = exp_resp(a, len, size);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom; s = 4'($urandom);
                axi_write(a, wd, s, id, len, size, r, gid, lat);
                if (er == 2'b00) model_write(a, wd, s);
                n_checks++; if ({r, gid} !== {er, id}) $display("FAIL rnd_b a=%h got=%b/%h want=%b/%h", a, r, gid, er, id); else n_pass++;
                n_checks++; if (lat != WR_LAT) $display("FAIL rnd_wr_lat got=%0d want=%0d", lat, WR_LAT); else n_pass++;
            end else begin
                axi_read(a, id, len, size, d, r, gid, last, lat);
                ed = (er == 2'b00) ? model[idx_of(a)] : 32'h0;
                n_checks++; if ({r, gid, last} !== {er, id, 1'b1}) $display("FAIL rnd_r a=%h got=%b/%h/%b want=%b/%h/1", a, r, gid, last, er, id); else n_pass++;
                n_checks++; if (d !== ed) $display("FAIL rnd_rdata a=%h got=%h want=%h", a, d, ed); else n_pass++;
                n_checks++; if (lat != RD_LAT) $display("FAIL rnd_rd_lat got=%0d want=%0d", lat, RD_LAT); else n_pass++;
            end
        end
    endtask

    // Read and write to one word hitting the same edge: read must see the old value.
    task automatic test_same_edge();
        logic [31:0] d, old; logic [1:0] rr, br; logic [3:0] rid_o, bid_o; logic last; int rl, wl;
        old = model[8];
        fork
            axi_read(32'h8000_0020, 4'h7, 8'd0, 3'd2, d, rr, rid_o, last, rl);
            axi_write(32'h8000_0020, 32'h1357_9BDF, 4'hF, 4'h8, 8'd0, 3'd2, br, bid_o, wl);
        join
        model_write(32'h8000_0020, 32'h1357_9BDF, 4'hF);
        n_checks++; if (d !== old) $display("FAIL same_edge_rdata got=%h want=%h", d, old); else n_pass++;
        n_checks++; if (br !== 2'b00) $display("FAIL same_edge_bresp got=%b want=00", br); else n_pass++;
        axi_read(32'h8000_0020, 4'h7, 8'd0, 3'd2, d, rr, rid_o, last, rl);
        n_checks++; if (d !== 32'h1357_9BDF) $display("FAIL same_edge_after got=%h want=13579bdf", d); else n_pass++;
    endtask

    // R held unaccepted while a write to the same word completes.
    task automatic test_stall();
        logic [31:0] old; logic [1:0] br; logic [3:0] bid_o; int wl, n = 0;
        old = model[4];
        bus.araddr = 32'h8000_0010; bus.arid = 4'hC; bus.arlen = 0; bus.arsize = 3'd2; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        while (!bus.rvalid && n < 50) begin tick(); n++; end
        fork
            axi_write(32'h8000_0010, 32'h2468_ACE0, 4'hF, 4'hE, 8'd0, 3'd2, br, bid_o, wl);
            for (int c = 0; c < 5; c++) begin
                n_checks++;
                if ({bus.rvalid, bus.rid, bus.rdata} !== {1'b1, 4'hC, old})
                    $display("FAIL stall_r_hold cyc=%0d got=%b/%h/%h want=1/c/%h", c, bus.rvalid, bus.rid, bus.rdata, old);
                else n_pass++;
                tick();
            end
        join
        model_write(32'h8000_0010, 32'h2468_ACE0, 4'hF);
        n_checks++; if ({br, bid_o} !== {2'b00, 4'hE}) $display("FAIL stall_b got=%b/%h want=00/e", br, bid_o); else n_pass++;
        n_checks++; if (wl != WR_LAT) $display("FAIL stall_wr_lat got=%0d want=%0d", wl, WR_LAT); else n_pass++;
        n_checks++; if (bus.rdata !== old) $display("FAIL stall_rdata_end got=%h want=%h", bus.rdata, old); else n_pass++;
        bus.rready = 1'b1; tick(); bus.rready = 1'b0;
        n_checks++; if (bus.rvalid !== 1'b0) $display("FAIL stall_r_drop got=%b want=0", bus.rvalid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, old; logic [1:0] r; logic [3:0] id; logic last; int lat;
        old = model[4];
        bus.araddr = 32'h8000_0010; bus.arid = 4'h1; bus.arlen = 0; bus.arsize = 3'd2; bus.arvalid = 1'b1;
        bus.awaddr = 32'h8000_0010; bus.awid = 4'h2; bus.awlen = 0; bus.awsize = 3'd2; bus.awvalid = 1'b1;
        bus.wdata = ~old; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n_checks++; if ({bus.arready, bus.awready, bus.wready} !== 3'b000)
            $display("FAIL rstmid_busy got=%b want=000", {bus.arready, bus.awready, bus.wready}); else n_pass++;
        reset = 1'b1;
        #2;
        n_checks++; if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b11100)
            $display("FAIL rstmid_async got=%b want=11100", {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}); else n_pass++;
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if ({bus.rvalid, bus.bvalid} !== 2'b00)
                $display("FAIL rstmid_valid cyc=%0d got=%b want=00", c, {bus.rvalid, bus.bvalid}); else n_pass++;
        end
        n_checks++; if ({bus.arready, bus.awready, bus.wready} !== 3'b111)
            $display("FAIL rstmid_ready got=%b want=111", {bus.arready, bus.awready, bus.wready}); else n_pass++;
        axi_read(32'h8000_0010, 4'h3, 8'd0, 3'd2, d, r, id, last, lat);
        n_checks++; if (d !== old) $display("FAIL rstmid_word got=%h want=%h", d, old); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_strobe();
        test_w_before_aw();
        test_errors();
        test_random();
        test_same_edge();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
